// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter (m0 = instruction bus, m1 = data bus)
// sharing one slave, with an abort path for a slave that never answers.
module wb_rr_arbiter #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CW      = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst,

  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  output logic [31:0] m0_rdt,
  output logic        m0_ack,
  output logic        m0_err,

  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  output logic [31:0] m1_rdt,
  output logic        m1_ack,
  output logic        m1_err,

  output logic [31:0] s_adr,
  output logic [31:0] s_dat,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic [31:0] s_rdt,
  input  logic        s_ack,
  input  logic        s_err,

  output logic [1:0]  grant,
  output logic        timeout_evt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit            TO_EN   = (TIMEOUT != 0);

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          lp_q, lp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // lp names the master that owns the slave in BUSY/ABORT, so it doubles as the owner select.
  logic [31:0] own_adr, own_dat;
  logic [3:0]  own_sel;
  logic        own_we, own_cyc, own_stb;

  assign own_adr = lp_q ? m1_adr : m0_adr;
  assign own_dat = lp_q ? m1_dat : m0_dat;
  assign own_sel = lp_q ? m1_sel : m0_sel;
  assign own_we  = lp_q ? m1_we  : m0_we;
  assign own_cyc = lp_q ? m1_cyc : m0_cyc;
  assign own_stb = lp_q ? m1_stb : m0_stb;

  logic stalled, timeout_hit;

  assign stalled     = own_stb && !s_ack && !s_err;
  // An ack or err arriving in the deadline cycle wins over the abort.
  assign timeout_hit = TO_EN && (state_q == BUSY) && own_cyc && stalled && (cnt_q == TO_VAL);

  // Next-state, arbitration and timeout counter.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    lp_d    = lp_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc || m1_cyc) begin
          state_d = BUSY;
          lp_d    = (m0_cyc && m1_cyc) ? ~lp_q : m1_cyc;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_d = IDLE;
        end else if (timeout_hit) begin
          state_d = ABORT;
        end else if (stalled) begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end
      ABORT: begin
        if (!own_cyc) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant_d = (state_d == BUSY) ? (lp_d ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: only control state is reset; every datapath value is a combinational pass-through.
  always_ff @(posedge wb_clk) begin
    // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
    if (wb_rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      lp_q    <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      lp_q    <= lp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Routing: only BUSY connects a master to the slave; reset silences everything at once.
  always_comb begin
    s_adr       = '0;
    s_dat       = '0;
    s_sel       = '0;
    s_we        = 1'b0;
    s_cyc       = 1'b0;
    s_stb       = 1'b0;
    m0_rdt      = '0;
    m0_ack      = 1'b0;
    m0_err      = 1'b0;
    m1_rdt      = '0;
    m1_ack      = 1'b0;
    m1_err      = 1'b0;
    timeout_evt = 1'b0;
    if (!wb_rst && state_q == BUSY) begin
      s_adr       = own_adr;
      s_dat       = own_dat;
      s_sel       = own_sel;
      s_we        = own_we;
      s_cyc       = own_cyc && !timeout_hit;
      s_stb       = own_stb && !timeout_hit;
      timeout_evt = timeout_hit;
      if (lp_q) begin
        m1_rdt = s_rdt;
        m1_ack = s_ack;
        m1_err = s_err || timeout_hit;
      end else begin
        m0_rdt = s_rdt;
        m0_ack = s_ack;
        m0_err = s_err || timeout_hit;
      end
    end
  end

  assign grant = wb_rst ? 2'b00 : grant_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios with literal expectations,
// then randomized masters/slave checked every cycle against a behavioural model.
module tb_wb_rr_arbiter;

  localparam int TO = 4;
  localparam int CW = 8;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_rdt;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb, s_ack, s_err;
  logic [31:0] m0_rdt, m1_rdt, s_adr, s_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [1:0]  grant;
  logic        timeout_evt;

  always #5 wb_clk = ~wb_clk;

  wb_rr_arbiter #(.TIMEOUT(TO), .CW(CW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr(m0_adr), .m0_dat(m0_dat), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdt(m0_rdt), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_adr(m1_adr), .m1_dat(m1_dat), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdt(m1_rdt), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_adr(s_adr), .s_dat(s_dat), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_rdt(s_rdt), .s_ack(s_ack), .s_err(s_err),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_m(input int i, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (i == 0) begin
      m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_adr = adr; m0_dat = dat; m0_sel = sel;
    end else begin
      m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_adr = adr; m1_dat = dat; m1_sel = sel;
    end
  endtask

  // Behavioural model: who owns the slave, whether that ownership is being aborted,
  // who was served last, and how many consecutive stalled cycles the owner has seen.
  int md_owner = -1;
  bit md_abort = 1'b0;
  int md_last  = 1;
  int md_stall = 0;

  initial forever begin : model_step
    bit          cyc [2];
    bit          stb [2];
    bit          we  [2];
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic [70:0] e_s;
    logic [33:0] e_m [2];
    logic [1:0]  e_g;
    bit          hit;
    int          g;
    @(negedge wb_clk);
    cyc = '{m0_cyc, m1_cyc};
    stb = '{m0_stb, m1_stb};
    we  = '{m0_we, m1_we};
    adr = '{m0_adr, m1_adr};
    dat = '{m0_dat, m1_dat};
    sel = '{m0_sel, m1_sel};
    e_s = '0;
    e_m[0] = '0;
    e_m[1] = '0;
    e_g = 2'b00;
    hit = 1'b0;
    if (!wb_rst && md_owner >= 0 && !md_abort) begin
      g   = md_owner;
      hit = (TO != 0) && (md_stall == TO) && cyc[g] && stb[g] && !s_ack && !s_err;
      e_s = {adr[g], dat[g], sel[g], we[g], cyc[g] && !hit, stb[g] && !hit};
      e_m[g] = {s_rdt, s_ack, s_err || hit};
      e_g = 2'(1 << g);
    end
    check("grant", grant, e_g);
    check("timeout_evt", timeout_evt, hit);
    check("slave_bus", {s_adr, s_dat, s_sel, s_we, s_cyc, s_stb}, e_s);
    check("m0_resp", {m0_rdt, m0_ack, m0_err}, e_m[0]);
    check("m1_resp", {m1_rdt, m1_ack, m1_err}, e_m[1]);
    // advance to the state that holds after this edge
    if (wb_rst) begin
      md_owner = -1; md_abort = 1'b0; md_last = 1; md_stall = 0;
    end else if (md_owner < 0) begin
      if (cyc[0] && cyc[1]) md_owner = 1 - md_last;
      else if (cyc[0])      md_owner = 0;
      else if (cyc[1])      md_owner = 1;
      if (md_owner >= 0) md_last = md_owner;
      md_stall = 0;
    end else if (!cyc[md_owner]) begin
      md_owner = -1; md_abort = 1'b0; md_stall = 0;
    end else if (md_abort) begin
      md_stall = 0;
    end else if (hit) begin
      md_abort = 1'b1; md_stall = 0;
    end else if (stb[md_owner] && !s_ack && !s_err) begin
      if (md_stall < (2 ** CW) - 1) md_stall = md_stall + 1;
    end else begin
      md_stall = 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          act  [2];
    int          beats[2];
    bit          mcyc [2];
    bit          mstb [2];
    bit          mwe  [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic [3:0]  msel [2];
    bit          got_ack[2];
    bit          got_err[2];
    int          mode;

    wb_rst = 1'b1;
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0, '0);
    s_ack = 1'b0; s_err = 1'b0; s_rdt = '0;
    step(); step();

    // Reset silences every output even with a live request and a stray ack.
    set_m(0, 1, 1, 0, 32'h0000_0040, 32'h0, 4'hF);
    s_ack = 1'b1; s_rdt = 32'hA5A5_A5A5;
    settle();
    check("rst_grant", grant, 2'b00);
    check("rst_s_cyc", s_cyc, 1'b0);
    check("rst_m0_ack", m0_ack, 1'b0);
    check("rst_m0_rdt", m0_rdt, 32'h0);
    step();
    wb_rst = 1'b0; s_ack = 1'b0;
    settle();
    check("post_rst_no_grant", grant, 2'b00);
    step(); settle();
    check("first_grant", grant, 2'b01);
    check("first_grant_s_cyc", s_cyc, 1'b1);
    set_m(0, 0, 0, 0, '0, '0, '0);
    step();

    // Lone m1 write, slave acks two cycles after the grant.
    set_m(1, 1, 1, 1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    settle();
    check("lone_idle_gap", grant, 2'b00);
    step(); settle();
    check("lone_grant", grant, 2'b10);
    check("lone_s_adr", s_adr, 32'h1000_0004);
    check("lone_s_dat", s_dat, 32'hDEAD_BEEF);
    check("lone_s_sel_we", {s_sel, s_we, s_cyc, s_stb}, 7'b1111_111);
    check("lone_no_early_ack", m1_ack, 1'b0);
    step(); step();
    s_ack = 1'b1; s_rdt = 32'h1234_5678;
    settle();
    check("lone_ack", {m1_ack, m1_err}, 2'b10);
    check("lone_rdt", m1_rdt, 32'h1234_5678);
    check("lone_m0_quiet", {m0_rdt, m0_ack, m0_err}, 34'h0);
    step();
    s_ack = 1'b0; s_rdt = '0;
    set_m(1, 0, 0, 0, '0, '0, '0);
    settle();
    check("lone_ack_one_cycle", m1_ack, 1'b0);
    step();

    // Ties after reset alternate m0, m1 across four rounds.
    wb_rst = 1'b1;
    step();
    wb_rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      set_m(0, 1, 1, 0, 32'h0000_0100 + r, 32'h0, 4'h1);
      set_m(1, 1, 1, 1, 32'h0000_0200 + r, 32'h5, 4'h2);
      step();
      s_ack = 1'b1;
      settle();
      check("tie_first", grant, 2'b01);
      check("tie_first_ack", {m0_ack, m1_ack}, 2'b10);
      step();
      s_ack = 1'b0;
      set_m(0, 0, 0, 0, 32'h0000_0100 + r, '0, '0);
      settle();
      check("tie_hold_on_drop", grant, 2'b01);
      check("tie_drop_s_adr", s_adr, 32'h0000_0100 + r);
      step(); settle();
      check("tie_gap", grant, 2'b00);
      step();
      s_ack = 1'b1;
      settle();
      check("tie_second", grant, 2'b10);
      check("tie_second_ack", {m0_ack, m1_ack}, 2'b01);
      step();
      s_ack = 1'b0;
      set_m(1, 0, 0, 0, '0, '0, '0);
      step();
    end

    // Timeout: the slave never answers; abort on the stalled deadline cycle.
    set_m(0, 1, 1, 0, 32'h0000_0300, 32'h0, 4'hF);
    step();
    for (int k = 0; k < TO; k++) begin
      settle();
      check("to_pre", {timeout_evt, m0_err, s_cyc}, 3'b001);
      step();
    end
    settle();
    check("to_evt", {timeout_evt, m0_err}, 2'b11);
    check("to_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    check("to_grant", grant, 2'b01);
    step();
    set_m(1, 1, 1, 0, 32'h0000_0400, 32'h0, 4'hF);
    settle();
    check("abort_quiet", {grant, s_cyc, timeout_evt, m0_err}, 5'b0);
    step(); settle();
    check("abort_ignores_m1", grant, 2'b00);
    set_m(0, 0, 0, 0, '0, '0, '0);
    step(); settle();
    check("abort_exit_idle", grant, 2'b00);
    step(); settle();
    check("after_abort_m1", grant, 2'b10);
    set_m(1, 0, 0, 0, '0, '0, '0);
    step();

    // Ack arriving exactly on the deadline cycle wins.
    set_m(0, 1, 1, 0, 32'h0000_0500, 32'h0, 4'hF);
    step();
    repeat (TO) step();
    s_ack = 1'b1; s_rdt = 32'hCAFE_F00D;
    settle();
    check("race_ack", {m0_ack, m0_err, timeout_evt, s_cyc}, 4'b1001);
    check("race_rdt", m0_rdt, 32'hCAFE_F00D);
    step();
    s_ack = 1'b0;
    set_m(0, 0, 0, 0, '0, '0, '0);
    step();

    // Reset in the middle of a BUSY cycle.
    set_m(0, 1, 1, 0, 32'h0000_0600, 32'h0, 4'hF);
    step(); settle();
    check("mid_busy_grant", grant, 2'b01);
    step();
    wb_rst = 1'b1; s_ack = 1'b1;
    settle();
    check("mid_rst_quiet", {s_cyc, m0_ack, grant}, 4'b0);
    step();
    wb_rst = 1'b0; s_ack = 1'b0;
    set_m(1, 1, 1, 0, 32'h0000_0700, 32'h0, 4'hF);
    step(); settle();
    check("tie_after_rst", grant, 2'b01);
    set_m(0, 0, 0, 0, '0, '0, '0);
    set_m(1, 0, 0, 0, '0, '0, '0);
    step(); step();

    // m0 holds cyc over three beats while m1 waits.
    set_m(0, 1, 1, 0, 32'h0000_0800, 32'h0, 4'hF);
    step();
    set_m(1, 1, 1, 0, 32'h0000_0900, 32'h0, 4'hF);
    for (int b = 0; b < 3; b++) begin
      set_m(0, 1, 1, 0, 32'h0000_0800 + 4 * b, 32'h0, 4'hF);
      s_ack = 1'b1;
      settle();
      check("mb_beat", {grant, m0_ack, m1_ack}, 4'b0110);
      check("mb_s_adr", s_adr, 32'h0000_0800 + 4 * b);
      step();
      s_ack = 1'b0;
      m0_stb = 1'b0;
      settle();
      check("mb_hold", grant, 2'b01);
      step();
    end
    m0_cyc = 1'b0;
    settle();
    check("mb_drop_hold", grant, 2'b01);
    step(); settle();
    check("mb_gap", grant, 2'b00);
    step(); settle();
    check("mb_m1_after", grant, 2'b10);
    set_m(1, 0, 0, 0, '0, '0, '0);
    step(); step();

    // Randomized traffic; the model process checks every cycle.
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; beats[i] = 0; mcyc[i] = 1'b0; mstb[i] = 1'b0; mwe[i] = 1'b0;
      madr[i] = '0; mdat[i] = '0; msel[i] = '0; got_ack[i] = 1'b0; got_err[i] = 1'b0;
    end
    mode = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          if (got_err[i] || (got_ack[i] && beats[i] == 0) || $urandom_range(0, 63) == 0) begin
            act[i] = 1'b0; mcyc[i] = 1'b0; mstb[i] = 1'b0;
          end else if (got_ack[i]) begin
            beats[i]--;
            mstb[i] = ($urandom_range(0, 3) != 0);
            madr[i] = $urandom; mdat[i] = $urandom; msel[i] = 4'($urandom); mwe[i] = 1'($urandom);
          end else if (!mstb[i]) begin
            mstb[i] = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          act[i] = 1'b1; mcyc[i] = 1'b1; mstb[i] = 1'b1; beats[i] = int'($urandom_range(0, 3));
          madr[i] = $urandom; mdat[i] = $urandom; msel[i] = 4'($urandom); mwe[i] = 1'($urandom);
        end
        set_m(i, mcyc[i], mstb[i], mwe[i], madr[i], mdat[i], msel[i]);
      end
      case (mode)
        0: begin
          s_ack = ($urandom_range(0, 1) == 1);
          s_err = !s_ack && ($urandom_range(0, 15) == 0);
        end
        1: begin
          s_ack = ($urandom_range(0, 7) == 0);
          s_err = 1'b0;
        end
        default: begin
          s_ack = ($urandom_range(0, 31) == 0);
          s_err = 1'b0;
        end
      endcase
      s_rdt  = $urandom;
      wb_rst = ($urandom_range(0, 599) == 0);
      @(negedge wb_clk);
      got_ack[0] = m0_ack; got_err[0] = m0_err;
      got_ack[1] = m1_ack; got_err[1] = m1_err;
      @(posedge wb_clk);
      #1;
    end

    wb_rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
